// File: rtl/pipeline_perf_monitor.sv
// Pipeline event-counter unit: cycle counter plus NUM_EVT event channels under a
// start/stop/clear FSM, with optional cycle-limit auto-stop, snapshot bank and registered readout.
module pipeline_perf_monitor #(
  parameter int unsigned NUM_EVT  = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = 0,
  parameter int unsigned SEL_W    = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               snap,
  input  logic [CNT_W-1:0]   cyc_limit,
  input  logic [SEL_W-1:0]   rd_sel,
  input  logic               rd_live,
  output logic [CNT_W-1:0]   rd_data,
  output logic               running,
  output logic               done,
  output logic [NUM_EVT:0]   ovf
);

  localparam int unsigned NCH = NUM_EVT + 1;

  if ((2 ** SEL_W) < NCH) begin : g_sel_check
    $error("rd_sel too narrow to address every channel");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] snap_q [NCH];
  logic [NCH-1:0]   inc;
  logic [NCH-1:0]   ovf_d;
  logic [CNT_W-1:0] rd_d;
  logic             auto_stop;
  logic             done_d;

  assign inc = {evt_i, 1'b1};

  // Counter increment with wrap or saturate; counting is gated by registered state only.
  always_comb begin
    ovf_d = ovf;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == S_RUN && inc[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT_MODE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign auto_stop = (state_q == S_RUN) && (cyc_limit != '0) && (cnt_d[0] == cyc_limit);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      done_d = auto_stop;
      case (state_q)
        S_RUN: begin
          if (stop || auto_stop) state_d = S_STOPPED;
        end
        default: begin
          if (start && !stop) state_d = S_RUN;
        end
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_d = rd_live ? cnt_q[i] : snap_q[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      running <= (state_d == S_RUN);
      done    <= done_d;
      rd_data <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      ovf <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      ovf <= ovf_d;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Snapshot takes pre-edge live values, so snap+clr captures the values being cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= '0;
    end else if (snap) begin
      for (int unsigned i = 0; i < NCH; i++) snap_q[i] <= cnt_q[i];
    end
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Scoreboard bench: wrap and saturate instances share stimulus; a channel-level model
// predicts each cycle's outputs into queues that a monitor pops and compares.
module tb_pipeline_perf_monitor;

  localparam int unsigned N    = 8;
  localparam int unsigned CW   = 5;
  localparam int unsigned SW   = 4;
  localparam int unsigned MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  evt = '0;
  logic          start = 1'b0, stop = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [CW-1:0] lim = '0;
  logic [SW-1:0] sel = '0;
  logic          live = 1'b0;
  logic [CW-1:0] nlim = '0;
  logic [SW-1:0] nsel = '0;
  logic          nlive = 1'b0;

  logic [CW-1:0] rd0, rd1;
  logic          run0, run1, done0, done1;
  logic [N:0]    ovf0, ovf1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [CW-1:0] rd;
    logic          run;
    logic          done;
    logic [N:0]    ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int unsigned mc [2][N+1];
  int unsigned ms [2][N+1];
  bit          mrun [2];
  logic [N:0]  movf [2];

  always #5 clk = ~clk;

  pipeline_perf_monitor #(.NUM_EVT(N), .CNT_W(CW), .SAT_MODE(0), .SEL_W(SW)) u_wrap (
    .clk(clk), .rstn(rstn), .evt_i(evt), .start(start), .stop(stop), .clr(clr), .snap(snap),
    .cyc_limit(lim), .rd_sel(sel), .rd_live(live), .rd_data(rd0), .running(run0),
    .done(done0), .ovf(ovf0));

  pipeline_perf_monitor #(.NUM_EVT(N), .CNT_W(CW), .SAT_MODE(1), .SEL_W(SW)) u_sat (
    .clk(clk), .rstn(rstn), .evt_i(evt), .start(start), .stop(stop), .clr(clr), .snap(snap),
    .cyc_limit(lim), .rd_sel(sel), .rd_live(live), .rd_data(rd1), .running(run1),
    .done(done1), .ovf(ovf1));

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mrun[m] = 1'b0;
      movf[m] = '0;
      for (int c = 0; c <= N; c++) begin
        mc[m][c] = 0;
        ms[m][c] = 0;
      end
    end
    q0.push_back('0);
    q1.push_back('0);
  endfunction

  // Model m=0 wraps, m=1 saturates; applies one clock edge of the channel rules.
  function automatic void model_step(input int m);
    exp_t        e;
    int unsigned r;
    bit          hit;
    bit          incr;
    r = 0;
    if (sel <= N) r = live ? mc[m][sel] : ms[m][sel];
    if (snap) for (int c = 0; c <= N; c++) ms[m][c] = mc[m][c];
    e.done = 1'b0;
    if (clr) begin
      for (int c = 0; c <= N; c++) mc[m][c] = 0;
      movf[m] = '0;
      mrun[m] = 1'b0;
    end else begin
      hit = 1'b0;
      if (mrun[m]) begin
        for (int c = 0; c <= N; c++) begin
          incr = (c == 0) ? 1'b1 : evt[c-1];
          if (incr) begin
            if (mc[m][c] == MAXV) begin
              movf[m][c] = 1'b1;
              if (m == 0) mc[m][c] = 0;
            end else begin
              mc[m][c] = mc[m][c] + 1;
            end
          end
        end
        hit = (lim != 0) && (mc[m][0] == lim);
      end
      e.done = hit;
      if (stop) mrun[m] = 1'b0;
      else if (mrun[m]) mrun[m] = !hit;
      else mrun[m] = start;
    end
    e.rd  = CW'(r);
    e.run = mrun[m];
    e.ovf = movf[m];
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic tick(input bit st, input bit sp, input bit cl, input bit sn, input logic [N-1:0] ev);
    @(negedge clk);
    rstn = 1'b1;
    start = st; stop = sp; clr = cl; snap = sn; evt = ev;
    lim = nlim; sel = nsel; live = nlive;
    model_step(0);
    model_step(1);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rstn = 1'b0;
      start = 1'b0; stop = 1'b0; clr = 1'b0; snap = 1'b0; evt = '0;
      model_reset();
    end
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, N'($urandom));
  endtask

  task automatic read_chk(input logic [SW-1:0] s, input bit lv, input int e0, input int e1,
                          input string nm);
    nsel = s;
    nlive = lv;
    tick(0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    cmp({nm, "_wrap"}, 32'(rd0), 32'(e0));
    cmp({nm, "_sat"}, 32'(rd1), 32'(e1));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("sb_rd_wrap", 32'(rd0), 32'(e.rd));
        cmp("sb_running_wrap", 32'(run0), 32'(e.run));
        cmp("sb_done_wrap", 32'(done0), 32'(e.done));
        cmp("sb_ovf_wrap", 32'(ovf0), 32'(e.ovf));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("sb_rd_sat", 32'(rd1), 32'(e.rd));
        cmp("sb_running_sat", 32'(run1), 32'(e.run));
        cmp("sb_done_sat", 32'(done1), 32'(e.done));
        cmp("sb_ovf_sat", 32'(ovf1), 32'(e.ovf));
      end
    end
  end

  initial begin : driver
    reset_cycles(3);

    // 1: start at cycle 0, stop at cycle 10, evt[0] held high, evt[1] low
    tick(1, 0, 0, 0, 8'h01);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 8'h01);
    tick(0, 1, 0, 0, 8'h01);
    read_chk(0, 1, 10, 10, "t1_ch0");
    read_chk(1, 1, 10, 10, "t1_ch1");
    read_chk(2, 1, 0, 0, "t1_ch2");

    // 2: run 5, hold 4, run 3
    tick(0, 0, 1, 0, '0);
    tick(1, 0, 0, 0, '0); plain(4); tick(0, 1, 0, 0, '0);
    plain(4);
    tick(1, 0, 0, 0, '0); plain(2); tick(0, 1, 0, 0, '0);
    read_chk(0, 1, 8, 8, "t2_ch0");

    // 3: auto-stop at 20, then resume
    tick(0, 0, 1, 0, '0);
    nlim = CW'(20);
    tick(1, 0, 0, 0, '0); plain(25);
    read_chk(0, 1, 20, 20, "t3_ch0");
    tick(1, 0, 0, 0, '0); plain(3); tick(0, 1, 0, 0, '0);
    read_chk(0, 1, 24, 24, "t3_resume");
    nlim = '0;

    // 4: MAXV+2 increments: wrap gives 1, saturate gives MAXV
    tick(0, 0, 1, 0, '0);
    tick(1, 0, 0, 0, '0); plain(MAXV + 1); tick(0, 1, 0, 0, '0);
    read_chk(0, 1, 1, MAXV, "t4_ch0");
    cmp("t4_ovf0_wrap", 32'(ovf0[0]), 1);
    cmp("t4_ovf0_sat", 32'(ovf1[0]), 1);
    tick(0, 0, 1, 0, '0);
    read_chk(0, 1, 0, 0, "t4_clr_ch0");
    cmp("t4_clr_ovf_wrap", 32'(ovf0), 0);
    cmp("t4_clr_ovf_sat", 32'(ovf1), 0);

    // 5: snap together with clr at ch0=12
    tick(1, 0, 0, 0, '0); plain(11); tick(0, 1, 0, 0, '0);
    tick(0, 0, 1, 1, '0);
    read_chk(0, 0, 12, 12, "t5_snap");
    read_chk(0, 1, 0, 0, "t5_live");
    cmp("t5_idle_running", 32'(run0), 0);

    // 6: start+stop together in IDLE, out-of-range select
    tick(1, 1, 0, 0, '0);
    read_chk(0, 1, 0, 0, "t6_idle_ch0");
    cmp("t6_idle_running", 32'(run0), 0);
    read_chk(SW'(N + 1), 1, 0, 0, "t6_sel_oor");

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) nlim = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, MAXV)) : '0;
      nsel  = SW'($urandom_range(0, 15));
      nlive = 1'($urandom);
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, N'($urandom));
    end

    // Reset pulled mid-run: outputs clear without waiting for a clock edge
    nlim = '0; nsel = '0; nlive = 1'b1;
    tick(0, 0, 1, 0, '0);
    tick(1, 0, 0, 0, '0); plain(6);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    cmp("rst_rd_wrap", 32'(rd0), 0);
    cmp("rst_running_wrap", 32'(run0), 0);
    cmp("rst_done_wrap", 32'(done0), 0);
    cmp("rst_ovf_wrap", 32'(ovf0), 0);
    cmp("rst_running_sat", 32'(run1), 0);
    start = 1'b0; stop = 1'b0; clr = 1'b0; snap = 1'b0; evt = '0;
    model_reset();
    reset_cycles(2);
    tick(1, 0, 0, 0, '0); plain(4); tick(0, 1, 0, 0, '0);
    read_chk(0, 1, 5, 5, "post_rst_ch0");

    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    #2;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
